// File: rtl/sqrt_floating_point.sv
// rtl/sqrt_floating_point.sv - multi-cycle sqrt / inverse sqrt on 8-bit-in, 12-bit-out fractions
// Restoring sqrt (2 root bits per cycle, 24-bit root) then optional restoring division 1/s.
module sqrt_floating_point (
  input  logic        clk,
  input  logic        rst,
  input  logic        doSqrt_i,
  input  logic        doInvSqrt_i,
  input  logic        s_i,
  input  logic [7:0]  f_i,
  input  logic [7:0]  e_i,
  input  logic        nlz_i,
  input  logic        isZ_i,
  input  logic        isInf_i,
  input  logic        isSNAN_i,
  input  logic        isQNAN_i,
  output logic        valid_o,
  output logic        s_o,
  output logic [11:0] f_o,
  output logic [7:0]  e_o,
  output logic        isOverflow_o,
  output logic        isUnderflow_o,
  output logic        isToRound_o
);

  typedef enum logic [2:0] {IDLE, PREP, SQRT, INV, DONE} state_t;

  state_t      state_q, state_d;
  logic        inv_q, inv_d, sgn_q, sgn_d;
  logic        nan_q, nan_d, zero_q, zero_d, inf_q, inf_d;
  logic [7:0]  frac_q, frac_d, exp_q, exp_d;
  logic [47:0] rad_q, rad_d;
  logic [24:0] rem_q, rem_d;
  logic [23:0] root_q, root_d;
  logic [23:0] drem_q, drem_d;
  logic [12:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        valid_q, valid_d, s_q, s_d, ovf_q, ovf_d, unf_q, unf_d, rnd_q, rnd_d;
  logic [11:0] fo_q, fo_d;
  logic [7:0]  eo_q, eo_d;

  logic        unused_nlz;
  assign unused_nlz = nlz_i;

  // One restoring sqrt step: bring down a radicand bit pair, try (root<<2)|1.
  function automatic logic [48:0] sqrt_step(input logic [24:0] rem, input logic [23:0] root,
                                            input logic [1:0] pair);
    if ({rem, pair} >= {1'b0, root, 2'b01})
      return {25'({rem, pair} - {1'b0, root, 2'b01}), root[22:0], 1'b1};
    else
      return {rem[22:0], pair, root[22:0], 1'b0};
  endfunction

  function automatic logic [24:0] div_step(input logic [23:0] drem, input logic [23:0] root);
    if ({drem, 1'b0} >= {1'b0, root})
      return {24'({drem, 1'b0} - {1'b0, root}), 1'b1};
    else
      return {drem[22:0], 1'b0, 1'b0};
  endfunction

  logic [48:0] sq1, sq2;
  logic [24:0] dv;
  assign sq1 = sqrt_step(rem_q, root_q, rad_q[47:46]);
  assign sq2 = sqrt_step(sq1[48:24], sq1[23:0], rad_q[45:44]);
  assign dv  = div_step(drem_q, root_q);

  // root = floor(sqrt(m/128) * 2^23); quotient = floor(2^35 / root) = floor(2^12 / s).
  logic [11:0] mag_f;
  logic        norm_shift, inexact;
  logic [7:0]  e_half, e_base;
  logic [9:0]  e_full;
  logic        res_ovf, res_unf;

  assign e_half = {exp_q[7], exp_q[7:1]};
  assign e_base = inv_q ? 8'd0 - e_half : e_half;

  always_comb begin
    if (!inv_q) begin
      norm_shift = ~root_q[23];
      mag_f      = root_q[23] ? root_q[23:12] : root_q[22:11];
      inexact    = (root_q[23] ? |root_q[11:0] : |root_q[10:0]) | (|rem_q);
    end else begin
      norm_shift = ~quo_q[12];
      mag_f      = quo_q[12] ? quo_q[12:1] : quo_q[11:0];
      inexact    = (quo_q[12] & quo_q[0]) | (|drem_q) | (|rem_q);
    end
  end

  assign e_full  = {{2{e_base[7]}}, e_base} - {9'd0, norm_shift};
  assign res_ovf = ~e_full[9] & (e_full[8] | e_full[7]);
  assign res_unf = e_full[9] & ~(e_full[8] & e_full[7]);

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    sgn_d   = sgn_q;
    nan_d   = nan_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    frac_d  = frac_q;
    exp_d   = exp_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    drem_d  = drem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    s_d     = s_q;
    fo_d    = fo_q;
    eo_d    = eo_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (doSqrt_i | doInvSqrt_i) begin
          inv_d   = ~doSqrt_i;
          sgn_d   = s_i;
          frac_d  = f_i;
          exp_d   = e_i;
          nan_d   = isSNAN_i | isQNAN_i;
          zero_d  = isZ_i;
          inf_d   = isInf_i;
          state_d = PREP;
        end
      end
      PREP: begin
        exp_d   = exp_q - {7'd0, exp_q[0]};
        rad_d   = exp_q[0] ? {frac_q, 1'b0, 39'd0} : {1'b0, frac_q, 39'd0};
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = SQRT;
      end
      SQRT: begin
        rem_d  = sq2[48:24];
        root_d = sq2[23:0];
        rad_d  = {rad_q[43:0], 4'd0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd11) begin
          drem_d  = 24'h200000;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = inv_q ? INV : DONE;
        end
      end
      INV: begin
        drem_d = dv[24:1];
        quo_d  = {quo_q[11:0], dv[0]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        s_d     = sgn_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        rnd_d   = 1'b0;
        if (nan_q) begin
          fo_d = 12'hC00;
          eo_d = 8'h7F;
        end else if (zero_q) begin
          fo_d = 12'h000;
          eo_d = inv_q ? 8'h7F : 8'h80;
        end else if (inf_q) begin
          fo_d = 12'h000;
          eo_d = inv_q ? 8'h80 : 8'h7F;
        end else if (res_ovf) begin
          fo_d  = 12'hFFF;
          eo_d  = 8'h7F;
          ovf_d = 1'b1;
        end else if (res_unf) begin
          fo_d  = 12'h000;
          eo_d  = 8'h80;
          unf_d = 1'b1;
        end else begin
          fo_d  = mag_f;
          eo_d  = e_full[7:0];
          rnd_d = inexact;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      sgn_q   <= 1'b0;
      nan_q   <= 1'b0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      frac_q  <= '0;
      exp_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      drem_q  <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      s_q     <= 1'b0;
      fo_q    <= '0;
      eo_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      rnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      sgn_q   <= sgn_d;
      nan_q   <= nan_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      frac_q  <= frac_d;
      exp_q   <= exp_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      drem_q  <= drem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      fo_q    <= fo_d;
      eo_q    <= eo_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      rnd_q   <= rnd_d;
    end
  end

  assign valid_o       = valid_q;
  assign s_o           = s_q;
  assign f_o           = fo_q;
  assign e_o           = eo_q;
  assign isOverflow_o  = ovf_q;
  assign isUnderflow_o = unf_q;
  assign isToRound_o   = rnd_q;

endmodule

// File: tb/tb_sqrt_floating_point.sv
// tb/tb_sqrt_floating_point.sv - self-checking bench for sqrt_floating_point
// Directed cases, specials, reset/busy behaviour and a randomized sweep against an integer model.
module tb_sqrt_floating_point;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        doSqrt_i = 1'b0, doInvSqrt_i = 1'b0, s_i = 1'b0, nlz_i = 1'b0;
  logic [7:0]  f_i = '0, e_i = '0;
  logic        isZ_i = 1'b0, isInf_i = 1'b0, isSNAN_i = 1'b0, isQNAN_i = 1'b0;
  logic        valid_o, s_o, isOverflow_o, isUnderflow_o, isToRound_o;
  logic [11:0] f_o;
  logic [7:0]  e_o;

  always #5 clk = ~clk;

  sqrt_floating_point dut (
    .clk(clk), .rst(rst), .doSqrt_i(doSqrt_i), .doInvSqrt_i(doInvSqrt_i),
    .s_i(s_i), .f_i(f_i), .e_i(e_i), .nlz_i(nlz_i), .isZ_i(isZ_i), .isInf_i(isInf_i),
    .isSNAN_i(isSNAN_i), .isQNAN_i(isQNAN_i), .valid_o(valid_o), .s_o(s_o), .f_o(f_o),
    .e_o(e_o), .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o),
    .isToRound_o(isToRound_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0]        cap_f;
  logic signed [7:0]  cap_e;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int msb8(input int f);
    for (int i = 7; i >= 0; i--) if (f[i]) return i;
    return 0;
  endfunction

  function automatic longint isqrt(input longint n);
    longint r;
    r = longint'($sqrt(real'(n)));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Reference: y = x^(1/2) or x^(-1/2), x = f/128 * 2^e; y = F/2048 * 2^E, F truncated.
  task automatic model(input bit inv, input int f, input int e, output int ef, output int ee, output int er);
    int     l, sh, k, t;
    longint n, fl;
    fl = f;
    ee = 0;
    if (!inv) begin
      l  = msb8(f) - 7 + e;
      ee = l >>> 1;
      sh = e + 15 - 2 * ee;
      n  = fl << sh;
      fl = isqrt(n);
      ef = int'(fl);
      er = (fl * fl != n) ? 1 : 0;
    end else begin
      for (int ex = 70; ex >= -70; ex--) begin
        t = 7 - e - 2 * ex;
        if (t > 61 || (t >= 0 && fl <= (64'sd1 <<< t))) begin
          ee = ex;
          break;
        end
      end
      k  = 29 - e - 2 * ee;
      n  = (64'sd1 <<< k) / fl;
      ef = int'(isqrt(n));
      er = (longint'(ef) * longint'(ef) * fl != (64'sd1 <<< k)) ? 1 : 0;
    end
  endtask

  task automatic expect_op(input string tag, input logic dsq, input logic dinv, input logic sgn,
                           input logic [7:0] f, input logic [7:0] e, input logic [3:0] fl,
                           input int ef, input int ee, input int er, input int elat, input bit near);
    int lat;
    @(negedge clk);
    doSqrt_i = dsq; doInvSqrt_i = dinv; s_i = sgn; f_i = f; e_i = e;
    {isZ_i, isInf_i, isSNAN_i, isQNAN_i} = fl;
    @(negedge clk);
    doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; s_i = ~sgn; f_i = 8'($urandom); e_i = 8'($urandom);
    {isZ_i, isInf_i, isSNAN_i, isQNAN_i} = 4'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    cap_f = f_o;
    cap_e = $signed(e_o);
    check({tag, "_lat"}, valid_o ? lat : -1, elat);
    if (near) check({tag, "_f_within_1ulp"}, (int'(f_o) == ef || int'(f_o) == ef + 1) ? 1 : 0, 1);
    else      check({tag, "_f"}, f_o, ef);
    check({tag, "_e"}, $signed(e_o), ee);
    check({tag, "_rnd"}, isToRound_o, er);
    check({tag, "_s"}, s_o, sgn);
    check({tag, "_ovf_unf"}, {isOverflow_o, isUnderflow_o}, 0);
    @(negedge clk);
    check({tag, "_pulse"}, valid_o, 0);
    if (!near) check({tag, "_hold_f"}, f_o, ef);
    check({tag, "_hold_e"}, $signed(e_o), ee);
  endtask

  initial begin
    int  ef, ee, er, es, seen;
    real x, y, err;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_f", f_o, 0);
    check("rst_e", e_o, 0);
    check("rst_flags", {s_o, isOverflow_o, isUnderflow_o, isToRound_o}, 0);
    rst = 1'b0;

    expect_op("sq_1",      1, 0, 0, 8'd128, 8'd0,   4'b0000, 12'h800, 0, 0, 14, 0);
    expect_op("sq_1p5625", 1, 0, 0, 8'd200, 8'd0,   4'b0000, 12'hA00, 0, 0, 14, 0);
    expect_op("sq_2_odd",  1, 0, 0, 8'd128, 8'd1,   4'b0000, 12'hB50, 0, 1, 14, 0);
    expect_op("sq_2_lowf", 1, 0, 0, 8'd64,  8'd2,   4'b0000, 12'hB50, 0, 1, 14, 0);
    expect_op("isq_4",     0, 1, 0, 8'd128, 8'd2,   4'b0000, 12'h800, -1, 0, 28, 0);
    expect_op("isq_eighth",0, 1, 0, 8'd128, 8'hFD,  4'b0000, 12'hB50, 1, 1, 28, 0);
    expect_op("sq_neg",    1, 0, 1, 8'd128, 8'd0,   4'b0000, 12'h800, 0, 0, 14, 0);
    expect_op("both_start",1, 1, 0, 8'd200, 8'd0,   4'b0000, 12'hA00, 0, 0, 14, 0);
    expect_op("isq_zero",  0, 1, 0, 8'd128, 8'd0,   4'b1000, 12'h000, 127, 0, 28, 0);
    expect_op("sq_zero",   1, 0, 0, 8'd128, 8'd0,   4'b1000, 12'h000, -128, 0, 14, 0);
    expect_op("sq_inf",    1, 0, 0, 8'd128, 8'd0,   4'b0100, 12'h000, 127, 0, 14, 0);
    expect_op("isq_inf",   0, 1, 0, 8'd128, 8'd0,   4'b0100, 12'h000, -128, 0, 28, 0);
    expect_op("sq_snan",   1, 0, 0, 8'd128, 8'd0,   4'b0010, 12'hC00, 127, 0, 14, 0);
    expect_op("isq_qnan",  0, 1, 1, 8'd100, 8'd3,   4'b1101, 12'hC00, 127, 0, 28, 0);

    // Reset in the middle of an invsqrt: no result may appear.
    @(negedge clk);
    doInvSqrt_i = 1'b1; f_i = 8'd128; e_i = 8'd2;
    @(negedge clk);
    doInvSqrt_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    check("midop_rst_no_valid", seen, 0);
    check("midop_rst_f", f_o, 0);
    expect_op("after_rst", 1, 0, 0, 8'd200, 8'd0, 4'b0000, 12'hA00, 0, 0, 14, 0);

    // A start while busy is ignored.
    @(negedge clk);
    doSqrt_i = 1'b1; f_i = 8'd200; e_i = 8'd0;
    @(negedge clk);
    doSqrt_i = 1'b0;
    seen = 0;
    for (int i = 1; i <= 44; i++) begin
      if (i == 5) begin doInvSqrt_i = 1'b1; f_i = 8'd64; e_i = 8'd1; end
      if (i == 6) doInvSqrt_i = 1'b0;
      if (valid_o) begin
        seen++;
        check("busy_lat", i - 1, 14);
        check("busy_f", f_o, 12'hA00);
      end
      @(negedge clk);
    end
    check("busy_single_result", seen, 1);

    // Sweep of fractions with random exponents, both operations.
    for (int f = 64; f <= 254; f++) begin
      for (int op = 0; op < 2; op++) begin
        es = $signed(8'($urandom));
        model(op == 1, f, es, ef, ee, er);
        expect_op(op == 1 ? "sweep_isq" : "sweep_sq", op == 0, op == 1, 1'($urandom),
                  8'(f), 8'(es), 4'b0000, ef, ee, er, op == 1 ? 28 : 14, op == 1);
        x = real'(f) / 128.0 * $pow(2.0, real'(es));
        y = real'(cap_f) / 2048.0 * $pow(2.0, real'(cap_e));
        err = (op == 0) ? (x - y * y) / x : (x - 1.0 / (y * y)) / x;
        if (err < 0.0) err = -err;
        check(op == 1 ? "relerr_isq" : "relerr_sq", (err < 1.0 / 1024.0) ? 1 : 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
